// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, default widths and operand-class helpers.
package muldiv_iter_pkg;

    localparam int unsigned MD_XLEN       = 32;
    localparam int unsigned MD_REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    function automatic logic md_is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic md_rs1_signed(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_rs2_signed(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring-divide
// step per cycle on operand magnitudes, sign applied in a final fixup cycle.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN       = MD_XLEN,
    parameter int unsigned REG_ADDR_W = MD_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  md_valid_i,
    output logic                  md_ready_o,
    input  logic [2:0]            md_op_i,
    input  logic [XLEN-1:0]       md_data1_i,
    input  logic [XLEN-1:0]       md_data2_i,
    input  logic [REG_ADDR_W-1:0] md_rd_i,
    input  logic                  md_flush_i,
    output logic                  md_valid_o,
    output logic [XLEN-1:0]       md_result_o,
    output logic [REG_ADDR_W-1:0] md_rd_o
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    md_op_e                op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  sign1_q, sign2_q;
    logic [XLEN-1:0]       opnd_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [XLEN-1:0]       result_q;
    logic [REG_ADDR_W-1:0] rd_out_q;

    // Request decode
    md_op_e          op_in;
    logic            accept;
    logic            s1_in, s2_in;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        op_in    = md_op_e'(md_op_i);
        accept   = md_valid_i && (state_q == S_IDLE) && !md_flush_i;
        s1_in    = md_rs1_signed(op_in) && md_data1_i[XLEN-1];
        s2_in    = md_rs2_signed(op_in) && md_data2_i[XLEN-1];
        abs1     = s1_in ? ('0 - md_data1_i) : md_data1_i;
        abs2     = s2_in ? ('0 - md_data2_i) : md_data2_i;
        div_zero = md_is_div(op_in) && (md_data2_i == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM)
                   && (md_data1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (md_data2_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = md_is_rem(op_in) ? md_data1_i : '1;
        end else begin
            special_res = md_is_rem(op_in) ? '0 : md_data1_i;
        end
    end

    // Shared adder: multiply adds the multiplicand into the high half; divide
    // subtracts the divisor from the shifted partial remainder (MSB = borrow).
    logic [XLEN+1:0]   add_a, add_b, sum;
    logic              add_cin;
    logic [XLEN:0]     shifted;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        if (md_is_div(op_q)) begin
            add_a   = {1'b0, shifted};
            add_b   = ~{2'b00, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {2'b00, acc_q[2*XLEN-1:XLEN]};
            add_b   = acc_q[0] ? {2'b00, opnd_q} : '0;
            add_cin = 1'b0;
        end
        sum      = add_a + add_b + {{(XLEN+1){1'b0}}, add_cin};
        div_ge   = !sum[XLEN+1];
        rem_next = div_ge ? sum[XLEN-1:0] : shifted[XLEN-1:0];
        if (md_is_div(op_q)) begin
            acc_next = {rem_next, acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_next = {sum[XLEN:0], acc_q[XLEN-1:1]};
        end
    end

    // Sign fixup and result select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sign1_q ^ sign2_q) ? ('0 - acc_q) : acc_q;
        quot_fix = (sign1_q ^ sign2_q) ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_fix  = sign1_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quot_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (md_flush_i) state_d = S_IDLE;
        md_ready_o = (state_q == S_IDLE);
        md_valid_o = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= MD_MUL;
            rd_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                rd_q    <= md_rd_i;
                sign1_q <= s1_in;
                sign2_q <= s2_in;
                cnt_q   <= CNT_W'(XLEN);
                // Multiplier / dividend sits in the low half and is shifted out.
                if (md_is_div(op_in)) begin
                    opnd_q <= abs2;
                    acc_q  <= {{XLEN{1'b0}}, abs1};
                end else begin
                    opnd_q <= abs1;
                    acc_q  <= {{XLEN{1'b0}}, abs2};
                end
                if (special) begin
                    result_q <= special_res;
                    rd_out_q <= md_rd_i;
                end
            end
            if (state_q == S_CALC && !md_flush_i) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == S_FIXUP && !md_flush_i) begin
                result_q <= fix_res;
                rd_out_q <= rd_q;
            end
        end
    end

    assign md_result_o = result_q;
    assign md_rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: arithmetic reference model compared
// against the DUT outputs every cycle, plus directed literal cases.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            md_valid_i = 1'b0;
    logic            md_ready_o;
    logic [2:0]      md_op_i = '0;
    logic [XLEN-1:0] md_data1_i = '0;
    logic [XLEN-1:0] md_data2_i = '0;
    logic [RW-1:0]   md_rd_i = '0;
    logic            md_flush_i = 1'b0;
    logic            md_valid_o;
    logic [XLEN-1:0] md_result_o;
    logic [RW-1:0]   md_rd_o;

    muldiv_iter #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .md_valid_i (md_valid_i),
        .md_ready_o (md_ready_o),
        .md_op_i    (md_op_i),
        .md_data1_i (md_data1_i),
        .md_data2_i (md_data2_i),
        .md_rd_i    (md_rd_i),
        .md_flush_i (md_flush_i),
        .md_valid_o (md_valid_o),
        .md_result_o(md_result_o),
        .md_rd_o    (md_rd_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        u;
        int                 sa, sb;
        sa = a;
        sb = b;
        case (op)
            MD_MUL:    return a * b;
            MD_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            MD_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            MD_MULHU:  begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            MD_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                       else return sa / sb;
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    if (b == 0) return a;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                       else return sa % sb;
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_special(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) return 1'b1;
        return (op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Index of the most recent rising edge (rising edges at 5, 15, 25 ...).
    function automatic int cur_edge();
        return int'(($time - 5) / 10);
    endfunction

    // Reference model: one outstanding op, due on a known edge.
    bit              pending = 1'b0;
    int              due = 0;
    logic [31:0]     exp_res = '0;
    logic [RW-1:0]   exp_rd = '0;
    logic [31:0]     last_res = '0;
    logic [RW-1:0]   last_rd = '0;

    always @(posedge clk or negedge clk or posedge reset) begin
        if (reset) begin
            pending  = 1'b0;
            last_res = '0;
            last_rd  = '0;
            if (!clk) begin
                check("rst_ready", md_ready_o, 1);
                check("rst_valid", md_valid_o, 0);
                check("rst_result", md_result_o, 0);
                check("rst_rd", md_rd_o, 0);
            end
        end else if (clk) begin
            if (md_flush_i) begin
                pending = 1'b0;
            end else if (md_valid_i && md_ready_o) begin
                pending = 1'b1;
                exp_res = ref_md(md_op_e'(md_op_i), md_data1_i, md_data2_i);
                exp_rd  = md_rd_i;
                due     = cur_edge() + (ref_special(md_op_e'(md_op_i), md_data1_i, md_data2_i) ? 0 : 33);
            end
        end else begin
            check("ready", md_ready_o, !pending);
            if (pending && due == cur_edge()) begin
                check("valid", md_valid_o, 1);
                check("result", md_result_o, exp_res);
                check("rd", md_rd_o, exp_rd);
                last_res = exp_res;
                last_rd  = exp_rd;
                pending  = 1'b0;
            end else begin
                check("valid", md_valid_o, 0);
                check("result_hold", md_result_o, last_res);
                check("rd_hold", md_rd_o, last_rd);
            end
        end
    end

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [RW-1:0] rd);
        int w;
        w = 0;
        while (!md_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", md_ready_o, 1);
        md_valid_i = 1'b1;
        md_op_i    = op;
        md_data1_i = a;
        md_data2_i = b;
        md_rd_i    = rd;
        @(negedge clk);
        md_valid_i = 1'b0;
        md_op_i    = 3'($urandom_range(0, 7));
        md_data1_i = $urandom;
        md_data2_i = $urandom;
        md_rd_i    = RW'($urandom);
    endtask

    task automatic run_check(input string name, input md_op_e op, input logic [31:0] a,
                             input logic [31:0] b, input logic [RW-1:0] rd,
                             input logic [31:0] exp, input int exp_cycle);
        int lat;
        issue(op, a, b, rd);
        lat = 0;
        while (!md_valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_cycle"}, lat + 1, exp_cycle);
        check(name, md_result_o, exp);
        check({name, "_rd"}, md_rd_o, rd);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("pin_mul", ref_md(MD_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulh", ref_md(MD_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu", ref_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", ref_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        check("pin_rem", ref_md(MD_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_check("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
        run_check("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
        run_check("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
        run_check("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 34);
        run_check("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
        run_check("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
        run_check("divu", MD_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 34);
        run_check("remu", MD_REMU, 32'd100, 32'd7, 5'd0, 32'd2, 34);
        run_check("divu_zero", MD_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_check("rem_zero", MD_REM, 32'd5, 32'd0, 5'd9, 32'd5, 1);
        run_check("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_check("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);

        // Flush during cycle 10 of a divide.
        issue(MD_DIV, 32'd1000, 32'd7, 5'd3);
        repeat (9) @(negedge clk);
        md_flush_i = 1'b1;
        @(negedge clk);
        md_flush_i = 1'b0;
        check("flush_ready", md_ready_o, 1);
        check("flush_valid", md_valid_o, 0);
        // Request together with flush must be dropped.
        md_valid_i = 1'b1;
        md_op_i    = MD_MUL;
        md_flush_i = 1'b1;
        @(negedge clk);
        md_valid_i = 1'b0;
        md_flush_i = 1'b0;
        check("flush_req_ready", md_ready_o, 1);
        run_check("mul_after_flush", MD_MUL, 32'd3, 32'd4, 5'd12, 32'd12, 34);

        // Asynchronous reset mid-calculation.
        issue(MD_MULHU, $urandom, $urandom, 5'd9);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ready", md_ready_o, 1);
        check("async_rst_valid", md_valid_o, 0);
        check("async_rst_result", md_result_o, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back requests.
        for (int i = 0; i < 6; i++) begin
            issue(md_op_e'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), RW'($urandom));
        end

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 250; i++) begin
            issue(md_op_e'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), RW'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 36)) @(negedge clk);
                md_flush_i = 1'b1;
                @(negedge clk);
                md_flush_i = 1'b0;
            end
        end

        repeat (40) @(negedge clk);
        check("drain_pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
